// File: rtl/clk_run_pkg.sv
// Shared types and defaults for the run/step clock controller.
package clk_run_pkg;

   // Controller states; the encodings are visible on the LEDs through state_o.
   typedef enum logic [2:0] {
      HALTED    = 3'd0,
      RUN       = 3'd1,
      STEP_LOW  = 3'd2,
      STEP_HIGH = 3'd3,
      STOPPED   = 3'd4
   } run_state_t;

   // 1 ms of stable input at a 50 MHz system clock.
   localparam int unsigned DEBOUNCE_DEFAULT = 50000;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes one raw board input, debounces it and emits a press pulse
// on every accepted rising edge of the debounced level.
module btn_debounce
   import clk_run_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic [CNT_W-1:0] stable_cnt;

   // Two-flop synchronizer for the asynchronous board input.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep sync_2 one full cycle behind sync_1;
         // blocking ones would collapse the two stages into a single flop.
         sync_1 <= raw;
         sync_2 <= sync_1;
      end
   end

   // Accept a new level only after it has differed from the current one for
   // DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable_cnt <= '0;
         level      <= 1'b0;
         press      <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sync_2 != level) begin
            if (stable_cnt == CNT_LAST) begin
               stable_cnt <= '0;
               level      <= sync_2;
               press      <= sync_2;
            end else begin
               stable_cnt <= stable_cnt + CNT_W'(1);
            end
         end else begin
            stable_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/clk_run_ctrl.sv
// Run/stop/single-step policy for the processor clock divider. Drives the
// divider's halt and set_freq inputs and counts completed single steps.
module clk_run_ctrl
   import clk_run_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int unsigned STEP_W          = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_run,
   input  logic              btn_step,
   input  logic              sw_fast,
   input  logic              cpu_halt,
   input  logic              slow_clk,
   output logic              halt,
   output logic              set_freq,
   output logic [2:0]        state_o,
   output logic [STEP_W-1:0] step_count
);

   logic       run_press;
   logic       step_press;
   logic       fast_level;
   logic       run_level_unused;
   logic       step_level_unused;
   logic       fast_press_unused;
   logic       slow_q;
   logic       slow_rise;
   logic       slow_fall;
   logic       step_done;
   run_state_t state;
   run_state_t state_nxt;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_run),
      .level (run_level_unused),
      .press (run_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_step),
      .level (step_level_unused),
      .press (step_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fast_sw (
      .clk   (clk),
      .reset (reset),
      .raw   (sw_fast),
      .level (fast_level),
      .press (fast_press_unused)
   );

   // Previous sample of the divided clock for edge detection; slow_clk moves
   // on the falling edge of clk, so it is already settled here.
   always_ff @(posedge clk) begin
      if (reset) slow_q <= 1'b0;
      else       slow_q <= slow_clk;
   end

   assign slow_rise = !slow_q &&  slow_clk;
   assign slow_fall =  slow_q && !slow_clk;

   // Next-state policy; cpu_halt outranks presses and slow-clock edges.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      state_nxt = state;
      step_done = 1'b0;
      case (state)
         HALTED: begin
            if (run_press)       state_nxt = RUN;
            else if (step_press) state_nxt = STEP_LOW;
         end
         RUN: begin
            if (cpu_halt)       state_nxt = STOPPED;
            else if (run_press) state_nxt = HALTED;
         end
         STEP_LOW: begin
            if (cpu_halt)       state_nxt = STOPPED;
            else if (slow_fall) state_nxt = STEP_HIGH;
         end
         STEP_HIGH: begin
            step_done = slow_rise;
            if (cpu_halt)       state_nxt = STOPPED;
            else if (slow_rise) state_nxt = HALTED;
         end
         STOPPED: state_nxt = STOPPED;
         default: state_nxt = HALTED;
      endcase
   end

   // State, divider controls and step counter; halt and set_freq are decoded
   // from the next state so they switch on the same edge as the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= HALTED;
         halt       <= 1'b1;
         set_freq   <= 1'b0;
         step_count <= '0;
      end else begin
         state    <= state_nxt;
         halt     <= (state_nxt == HALTED) || (state_nxt == STOPPED);
         // Stepping always runs at the slow rate so the divider has ample
         // margin to see halt before its next toggle.
         set_freq <= (state_nxt == STEP_LOW || state_nxt == STEP_HIGH) ? 1'b0 : fast_level;
         if (step_done) step_count <= step_count + STEP_W'(1);
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_clk_run_ctrl.sv
// Directed bench for clk_run_ctrl with a behavioural clock-divider model.
module tb_clk_run_ctrl;

   localparam int unsigned DB = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        btn_run = 1'b0;
   logic        btn_step = 1'b0;
   logic        sw_fast = 1'b0;
   logic        cpu_halt = 1'b0;
   logic        slow_clk;
   logic        halt;
   logic        set_freq;
   logic [2:0]  state_o;
   logic [15:0] step_count;

   // second instance with a 2-bit counter to reach the wrap point quickly
   logic        btn_step2 = 1'b0;
   logic        slow_clk2;
   logic        halt2;
   logic        set_freq2;
   logic [2:0]  state2;
   logic [1:0]  count2;

   int checks = 0;
   int errors = 0;
   int div_cnt, div_cnt2;

   always #5 clk = ~clk;

   clk_run_ctrl #(.DEBOUNCE_CYCLES(DB), .STEP_W(16)) dut (
      .clk(clk), .reset(reset), .btn_run(btn_run), .btn_step(btn_step),
      .sw_fast(sw_fast), .cpu_halt(cpu_halt), .slow_clk(slow_clk),
      .halt(halt), .set_freq(set_freq), .state_o(state_o), .step_count(step_count)
   );

   clk_run_ctrl #(.DEBOUNCE_CYCLES(DB), .STEP_W(2)) dut2 (
      .clk(clk), .reset(reset), .btn_run(1'b0), .btn_step(btn_step2),
      .sw_fast(1'b0), .cpu_halt(1'b0), .slow_clk(slow_clk2),
      .halt(halt2), .set_freq(set_freq2), .state_o(state2), .step_count(count2)
   );

   // Divider model: toggles on negedge clk every half-period, frozen while halt.
   always @(negedge clk) begin
      if (reset) begin
         div_cnt  <= 0;
         slow_clk <= 1'b0;
      end else if (!halt) begin
         if (div_cnt >= (set_freq ? 4 : 2500) - 1) begin
            div_cnt  <= 0;
            slow_clk <= ~slow_clk;
         end else begin
            div_cnt <= div_cnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         div_cnt2  <= 0;
         slow_clk2 <= 1'b0;
      end else if (!halt2) begin
         if (div_cnt2 >= 2) begin
            div_cnt2  <= 0;
            slow_clk2 <= ~slow_clk2;
         end else begin
            div_cnt2 <= div_cnt2 + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
   endtask

   // Hold the selected buttons for 10 cycles, then release long enough to re-debounce.
   task automatic press(input bit run, input bit step);
      btn_run  = run;
      btn_step = step;
      repeat (10) tick();
      btn_run  = 1'b0;
      btn_step = 1'b0;
      repeat (10) tick();
   endtask

   // Single step on the main instance, observing the whole halt-low window.
   task automatic do_step(input string tag, input logic [15:0] exp_count, input logic exp_fast);
      int   cyc, falls, lag, fast_seen;
      logic prev;
      cyc = 0; falls = 0; lag = 0; fast_seen = 0;
      btn_step = 1'b1;
      while (halt && cyc < 30) begin
         tick(); cyc++;
         if (cyc == 10) btn_step = 1'b0;
      end
      check({tag, " halt_drop"}, halt, 1'b0);
      prev = slow_clk;
      while (!halt && cyc < 20000) begin
         tick(); cyc++;
         if (cyc == 10) btn_step = 1'b0;
         if (!halt && set_freq) fast_seen = 1;
         if (prev && !slow_clk) falls++;
         if (!prev && slow_clk) lag = 0;
         else                   lag++;
         prev = slow_clk;
      end
      btn_step = 1'b0;
      check({tag, " halt_back"}, halt, 1'b1);
      check({tag, " one_fall"}, falls, 1);
      check({tag, " ends_high"}, slow_clk, 1'b1);
      check({tag, " lag_le2"}, lag <= 2, 1'b1);
      check({tag, " slow_rate"}, fast_seen, 0);
      check({tag, " state"}, state_o, 3'd0);
      check({tag, " count"}, step_count, exp_count);
      check({tag, " set_freq"}, set_freq, exp_fast);
      repeat (10) tick();
   endtask

   // Single step on the 2-bit instance.
   task automatic do_step2(input logic [1:0] exp_count);
      int cyc;
      bit low_seen;
      cyc = 0; low_seen = 0;
      btn_step2 = 1'b1;
      while (!(low_seen && halt2) && cyc < 300) begin
         tick(); cyc++;
         if (cyc == 10) btn_step2 = 1'b0;
         if (!halt2) low_seen = 1;
      end
      btn_step2 = 1'b0;
      repeat (10) tick();
      check("wrap state", state2, 3'd0);
      check("wrap count", count2, exp_count);
   endtask

   initial begin
      int changes, latency;
      logic [2:0] prev_state;

      // Reset
      do_reset();
      check("reset halt", halt, 1'b1);
      check("reset set_freq", set_freq, 1'b0);
      check("reset state", state_o, 3'd0);
      check("reset count", step_count, 16'd0);
      check("reset halt2", halt2, 1'b1);
      check("reset count2", count2, 2'd0);

      // Debounce: 3-cycle glitch is rejected
      btn_run = 1'b1;
      repeat (3) tick();
      btn_run = 1'b0;
      repeat (10) tick();
      check("glitch state", state_o, 3'd0);
      check("glitch halt", halt, 1'b1);

      // Held press: one transition, 2 sync + 4 debounce + 1 state edge
      changes = 0; latency = 0;
      prev_state = state_o;
      btn_run = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         if (i == 11) btn_run = 1'b0;
         tick();
         if (state_o != prev_state) begin
            changes++;
            if (latency == 0) latency = i;
         end
         prev_state = state_o;
      end
      check("hold changes", changes, 1);
      check("hold latency", latency, 7);
      check("hold state", state_o, 3'd1);
      check("hold halt", halt, 1'b0);
      press(1'b1, 1'b0);
      check("repress state", state_o, 3'd0);
      check("repress halt", halt, 1'b1);

      // Single steps on the slow divider
      do_step("step1", 16'd1, 1'b0);
      do_step("step2", 16'd2, 1'b0);
      do_step("step3", 16'd3, 1'b0);
      do_step("step4", 16'd4, 1'b0);

      // Fast switch
      sw_fast = 1'b1;
      repeat (10) tick();
      press(1'b1, 1'b0);
      check("fast run state", state_o, 3'd1);
      check("fast run set_freq", set_freq, 1'b1);
      press(1'b1, 1'b0);
      check("fast halted state", state_o, 3'd0);
      check("fast halted set_freq", set_freq, 1'b1);
      do_step("fast step", 16'd5, 1'b1);
      sw_fast = 1'b0;
      repeat (10) tick();
      check("fast off set_freq", set_freq, 1'b0);

      // Processor halt
      press(1'b1, 1'b0);
      check("cpu run state", state_o, 3'd1);
      cpu_halt = 1'b1;
      tick();
      check("cpu stop state", state_o, 3'd4);
      check("cpu stop halt", halt, 1'b1);
      cpu_halt = 1'b0;
      press(1'b1, 1'b0);
      check("stopped run", state_o, 3'd4);
      press(1'b0, 1'b1);
      check("stopped step", state_o, 3'd4);
      check("stopped halt", halt, 1'b1);
      do_reset();
      check("stop reset state", state_o, 3'd0);
      check("stop reset halt", halt, 1'b1);

      // Run and step pressed together: run wins
      press(1'b1, 1'b1);
      check("both state", state_o, 3'd1);
      check("both halt", halt, 1'b0);
      press(1'b1, 1'b0);
      check("both back", state_o, 3'd0);

      // Reset during STEP_HIGH
      begin
         int cyc;
         cyc = 0;
         btn_step = 1'b1;
         while (state_o != 3'd3 && cyc < 20000) begin
            tick(); cyc++;
            if (cyc == 10) btn_step = 1'b0;
         end
         btn_step = 1'b0;
         check("reach step_high", state_o, 3'd3);
         check("step_high halt", halt, 1'b0);
         do_reset();
         check("midstep state", state_o, 3'd0);
         check("midstep halt", halt, 1'b1);
         check("midstep count", step_count, 16'd0);
      end

      // Counter wrap on the 2-bit instance: 3 -> 0
      do_step2(2'd1);
      do_step2(2'd2);
      do_step2(2'd3);
      do_step2(2'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
